// File: rtl/jls_bit_packer.sv
// JPEG-LS regular-mode bit packer: appends unary/value code descriptors MSB-first,
// extracts up to four marker-stuffed bytes per cycle and drains the tail on flush.
module jls_bit_packer #(
  parameter int ACC_W = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_vl,
  input  logic [4:0]  i_zc,
  input  logic [8:0]  i_bv,
  input  logic [3:0]  i_bc,
  input  logic        i_flush,
  output logic        o_vl,
  output logic [31:0] o_data,
  output logic [2:0]  o_cnt,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ovf
);
  localparam int SYM_W  = 33;
  localparam int EXT_W  = ACC_W + SYM_W;
  localparam int CNT_W  = $clog2(ACC_W + 1);
  localparam int ECNT_W = $clog2(EXT_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_TAIL} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_prev_ff;
  logic              r_ovf;
  logic              r_vl;
  logic [31:0]       r_data;
  logic [2:0]        r_ocnt;
  logic              r_done;

  logic              w_accept;
  logic [3:0]        w_bc;
  logic [5:0]        w_sym_len;
  logic [SYM_W-1:0]  w_sym_val;
  logic [SYM_W-1:0]  w_sym_la;
  logic [EXT_W-1:0]  w_ext;
  logic [ECNT_W-1:0] w_ext_cnt;

  logic [EXT_W-1:0]  w_data;
  logic [ECNT_W-1:0] w_rem;
  logic              w_ff;
  logic [2:0]        w_nbytes;
  logic [31:0]       w_word;
  logic [3:0]        w_need;
  logic [7:0]        w_b;
  logic [7:0]        w_pad_byte;
  logic              w_pad;
  logic              w_drain_end;
  logic              w_tail_req;

  logic [31:0]       w_word_next;
  logic [2:0]        w_cnt_next;
  logic              w_done_next;
  logic [ACC_W-1:0]  w_acc_next;
  logic [CNT_W-1:0]  w_bits_next;
  logic              w_ff_next;
  logic              w_ovf_next;

  // Symbol is right-aligned as {1, value bits}, then left-aligned to its length.
  assign w_accept = i_vl && (r_state == S_IDLE) && (i_zc != 5'd0);

  always_comb begin
    w_bc      = (i_bc > 4'd9) ? 4'd9 : i_bc;
    w_sym_len = 6'd0;
    w_sym_val = '0;
    if (w_accept) begin
      w_sym_len = {1'b0, i_zc} + {2'b00, w_bc};
      w_sym_val = (SYM_W'(1) << w_bc) | SYM_W'(i_bv & ((9'd1 << w_bc) - 9'd1));
    end
    w_sym_la = w_sym_val << (6'(SYM_W) - w_sym_len);
  end

  assign w_ext     = {r_acc, {SYM_W{1'b0}}} | ({w_sym_la, {ACC_W{1'b0}}} >> r_cnt);
  assign w_ext_cnt = ECNT_W'(r_cnt) + ECNT_W'(w_sym_len);

  // Four-deep extraction chain; a stage that cannot complete a byte stalls all later ones.
  always_comb begin
    w_data   = w_ext;
    w_rem    = w_ext_cnt;
    w_ff     = r_prev_ff;
    w_nbytes = 3'd0;
    w_word   = '0;
    w_need   = 4'd8;
    w_b      = 8'd0;
    for (int k = 0; k < 4; k++) begin
      w_need = w_ff ? 4'd7 : 4'd8;
      if (w_rem >= ECNT_W'(w_need)) begin
        w_b = w_ff ? {1'b0, w_data[EXT_W-1 -: 7]} : w_data[EXT_W-1 -: 8];
        w_word[8*(3-k) +: 8] = w_b;
        w_data   = w_data << w_need;
        w_rem    = w_rem - ECNT_W'(w_need);
        w_ff     = (w_b == 8'hFF);
        w_nbytes = w_nbytes + 3'd1;
      end
    end
  end

  // Drain tail: bits below the count are zero, so the pad byte is just the top bits.
  // A trailing 0xFF with an empty accumulator pads to the stuffed 0x00 in place.
  assign w_pad_byte = w_ff ? {1'b0, w_data[EXT_W-1 -: 7]} : w_data[EXT_W-1 -: 8];

  always_comb begin
    w_pad       = 1'b0;
    w_drain_end = 1'b0;
    w_tail_req  = 1'b0;
    if (w_nbytes != 3'd4) begin
      w_pad       = (w_rem != '0) || w_ff;
      w_drain_end = 1'b1;
    end else if (w_rem == '0) begin
      w_drain_end = 1'b1;
      w_tail_req  = w_ff;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_flush) w_state_next = S_DRAIN;
      S_DRAIN: if (w_drain_end) w_state_next = w_tail_req ? S_TAIL : S_IDLE;
      S_TAIL:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != S_IDLE);
    w_word_next = w_word;
    w_cnt_next  = w_nbytes;
    w_done_next = 1'b0;
    w_acc_next  = w_data[EXT_W-1 -: ACC_W];
    w_bits_next = CNT_W'(w_rem);
    w_ff_next   = w_ff;
    w_ovf_next  = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (w_rem > ECNT_W'(ACC_W)) begin
          w_ovf_next  = 1'b1;
          w_bits_next = CNT_W'(ACC_W);
        end
      end
      S_DRAIN: begin
        if (i_vl || i_flush) w_ovf_next = 1'b1;
        if (w_pad) begin
          w_word_next = w_word | ({w_pad_byte, 24'd0} >> {w_nbytes, 3'b000});
          w_cnt_next  = w_nbytes + 3'd1;
          w_acc_next  = '0;
          w_bits_next = '0;
          w_ff_next   = 1'b0;
        end
        w_done_next = w_drain_end && !w_tail_req;
      end
      S_TAIL: begin
        if (i_vl || i_flush) w_ovf_next = 1'b1;
        w_word_next = 32'd0;
        w_cnt_next  = 3'd1;
        w_done_next = 1'b1;
        w_ff_next   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_prev_ff <= 1'b0;
      r_ovf     <= 1'b0;
      r_vl      <= 1'b0;
      r_data    <= 32'd0;
      r_ocnt    <= 3'd0;
      r_done    <= 1'b0;
    end else begin
      r_acc     <= w_acc_next;
      r_cnt     <= w_bits_next;
      r_prev_ff <= w_ff_next;
      r_ovf     <= w_ovf_next;
      r_vl      <= (w_cnt_next != 3'd0);
      r_data    <= w_word_next;
      r_ocnt    <= w_cnt_next;
      r_done    <= w_done_next;
    end
  end

  assign o_vl   = r_vl;
  assign o_data = r_data;
  assign o_cnt  = r_ocnt;
  assign o_done = r_done;
  assign o_ovf  = r_ovf;
endmodule

// File: tb/tb_jls_bit_packer.sv
// Bench for jls_bit_packer: directed scenarios plus random symbols checked cycle by
// cycle against a bit-queue model of the stuffed byte stream.
module tb_jls_bit_packer;
  localparam int ACC_W = 64;

  logic        clk;
  logic        rstn;
  logic        i_vl;
  logic [4:0]  i_zc;
  logic [8:0]  i_bv;
  logic [3:0]  i_bc;
  logic        i_flush;
  logic        o_vl;
  logic [31:0] o_data;
  logic [2:0]  o_cnt;
  logic        o_busy;
  logic        o_done;
  logic        o_ovf;

  int n_vec;
  int n_err;

  // Model state: pending bits oldest-first, stuffing flag, flush phase, sticky error.
  bit mq[$];
  bit m_ff;
  int m_mode;
  bit m_ovf;
  logic [38:0] got;
  logic [38:0] exp;

  jls_bit_packer #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rstn(rstn), .i_vl(i_vl), .i_zc(i_zc), .i_bv(i_bv), .i_bc(i_bc),
    .i_flush(i_flush), .o_vl(o_vl), .o_data(o_data), .o_cnt(o_cnt),
    .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_ff   = 1'b0;
    m_mode = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    i_vl = 1'b0; i_zc = '0; i_bv = '0; i_bc = '0; i_flush = 1'b0;
    #2;
    rstn = 1'b1;
    model_reset();
  endtask

  // Drive one cycle, advance the model, sample the registered outputs 1 ns after the edge.
  task automatic step(input logic vl, input logic [4:0] zc, input logic [8:0] bv,
                      input logic [3:0] bc, input logic fl);
    logic [31:0] d;
    logic [7:0]  b;
    logic        done;
    int n, need, z, ebc;
    i_vl = vl; i_zc = zc; i_bv = bv; i_bc = bc; i_flush = fl;
    d = '0; n = 0; done = 1'b0;
    if (m_mode != 0 && (vl || fl)) m_ovf = 1'b1;
    if (m_mode == 0 && vl && zc != 0) begin
      z   = int'(zc);
      ebc = (bc > 9) ? 9 : int'(bc);
      for (int k = 0; k < z - 1; k++) mq.push_back(1'b0);
      mq.push_back(1'b1);
      for (int k = ebc - 1; k >= 0; k--) mq.push_back(bv[k]);
    end
    if (m_mode == 2) begin
      n = 1; done = 1'b1; m_ff = 1'b0; m_mode = 0;
    end else begin
      need = m_ff ? 7 : 8;
      while (n < 4 && mq.size() >= need) begin
        b = 8'd0;
        for (int k = need - 1; k >= 0; k--) b[k] = mq.pop_front();
        d[8*(3-n) +: 8] = b;
        n++;
        m_ff = (b == 8'hFF);
        need = m_ff ? 7 : 8;
      end
      if (m_mode == 0) begin
        while (mq.size() > ACC_W) begin
          void'(mq.pop_back());
          m_ovf = 1'b1;
        end
        if (fl) m_mode = 1;
      end else if (n < 4) begin
        if (mq.size() > 0 || m_ff) begin
          b = 8'd0;
          for (int k = need - 1; k >= 0; k--) b[k] = (mq.size() > 0) ? mq.pop_front() : 1'b0;
          d[8*(3-n) +: 8] = b;
          n++;
          m_ff = 1'b0;
        end
        done = 1'b1; m_mode = 0;
      end else if (mq.size() == 0) begin
        if (m_ff) m_mode = 2;
        else begin done = 1'b1; m_mode = 0; end
      end
    end
    exp = {(n != 0), 3'(n), d, done, (m_mode != 0), m_ovf};
    @(posedge clk);
    #1;
    got = {o_vl, o_cnt, o_data, o_done, o_busy, o_ovf};
    if (o_vl || o_done)
      $display("t=%0t out vl=%0b cnt=%0d data=%h done=%0b", $time, o_vl, o_cnt, o_data, o_done);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    i_vl = 1'b0; i_zc = '0; i_bv = '0; i_bc = '0; i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({o_vl, o_cnt, o_data, o_done, o_busy, o_ovf} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected 0 (vl,cnt,data,done,busy,ovf)",
               {o_vl, o_cnt, o_data, o_done, o_busy, o_ovf});
    end
    rstn = 1'b1;
    model_reset();
    step(1'b0, 5'd0, 9'd0, 4'd0, 1'b0);
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL reset_idle: got %h expected %h", got, exp); end
  endtask

  task automatic test_stuffing();
    apply_reset();
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 5'd1, 9'd0, 4'd0, 1'b0);
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL stuffing_model cyc %0d: got %h expected %h", i, got, exp); end
      if (i == 8) begin
        n_vec++;
        if (o_vl !== 1'b1 || o_cnt !== 3'd1 || o_data !== 32'hFF00_0000) begin
          n_err++; $display("FAIL stuffing_ff: got cnt=%0d data=%h expected cnt=1 data=ff000000", o_cnt, o_data);
        end
      end
      if (i == 15) begin
        n_vec++;
        if (o_vl !== 1'b1 || o_cnt !== 3'd1 || o_data !== 32'h7F00_0000) begin
          n_err++; $display("FAIL stuffing_7f: got cnt=%0d data=%h expected cnt=1 data=7f000000", o_cnt, o_data);
        end
      end
    end
  endtask

  task automatic test_short_flush();
    int busy_cycles;
    bit seen;
    apply_reset();
    busy_cycles = 0; seen = 1'b0;
    step(1'b1, 5'd3, 9'd2, 4'd2, 1'b0);
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL short_sym: got %h expected %h", got, exp); end
    step(1'b0, 5'd0, 9'd0, 4'd0, 1'b1);
    busy_cycles += int'(o_busy);
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL short_flush: got %h expected %h", got, exp); end
    for (int i = 0; i < 6 && !seen; i++) begin
      step(1'b0, 5'd0, 9'd0, 4'd0, 1'b0);
      busy_cycles += int'(o_busy);
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL short_drain: got %h expected %h", got, exp); end
      if (o_done) begin
        seen = 1'b1;
        n_vec++;
        if (o_vl !== 1'b1 || o_cnt !== 3'd1 || o_data !== 32'h3000_0000) begin
          n_err++; $display("FAIL short_byte: got cnt=%0d data=%h expected cnt=1 data=30000000", o_cnt, o_data);
        end
      end
    end
    n_vec++;
    if (!seen || busy_cycles != 1) begin
      n_err++; $display("FAIL short_busy: got done=%0b busy_cycles=%0d expected done=1 busy_cycles=1", seen, busy_cycles);
    end
  endtask

  task automatic test_escape();
    apply_reset();
    step(1'b1, 5'd24, 9'h55, 4'd8, 1'b0);
    n_vec++;
    if (o_vl !== 1'b1 || o_cnt !== 3'd4 || o_data !== 32'h0000_0155) begin
      n_err++; $display("FAIL escape: got cnt=%0d data=%h expected cnt=4 data=00000155", o_cnt, o_data);
    end
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL escape_model: got %h expected %h", got, exp); end
  endtask

  task automatic test_flush_ff();
    bit seen;
    apply_reset();
    seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 5'd1, 9'd0, 4'd0, 1'b0);
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL flushff_sym cyc %0d: got %h expected %h", i, got, exp); end
    end
    n_vec++;
    if (o_data !== 32'hFF00_0000 || o_cnt !== 3'd1) begin
      n_err++; $display("FAIL flushff_ff: got cnt=%0d data=%h expected cnt=1 data=ff000000", o_cnt, o_data);
    end
    step(1'b0, 5'd0, 9'd0, 4'd0, 1'b1);
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL flushff_flush: got %h expected %h", got, exp); end
    for (int i = 0; i < 4 && !seen; i++) begin
      step(1'b0, 5'd0, 9'd0, 4'd0, 1'b0);
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL flushff_drain: got %h expected %h", got, exp); end
      if (o_vl || o_done) begin
        seen = 1'b1;
        n_vec++;
        if (o_done !== 1'b1 || o_cnt !== 3'd1 || o_data !== 32'h0000_0000) begin
          n_err++; $display("FAIL flushff_zero: got done=%0b cnt=%0d data=%h expected done=1 cnt=1 data=0", o_done, o_cnt, o_data);
        end
      end
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL flushff_timeout: got no output expected 0x00 with done"); end
  endtask

  task automatic test_noop();
    bit seen;
    apply_reset();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'd0, 9'($urandom), 4'd5, 1'b0);
      n_vec++;
      if (o_vl !== 1'b0 || got !== exp) begin
        n_err++; $display("FAIL noop cyc %0d: got %h expected %h", i, got, exp);
      end
    end
    step(1'b0, 5'd0, 9'd0, 4'd0, 1'b1);
    for (int i = 0; i < 4 && !seen; i++) begin
      step(1'b0, 5'd0, 9'd0, 4'd0, 1'b0);
      n_vec++;
      if (o_vl !== 1'b0 || got !== exp) begin
        n_err++; $display("FAIL noop_flush: got %h expected %h", got, exp);
      end
      if (o_done) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL noop_done: got done=0 expected done=1"); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    apply_reset();
    seen = 1'b0;
    step(1'b1, 5'd3, 9'd2, 4'd2, 1'b0);
    rstn = 1'b0;
    i_vl = 1'b0; i_zc = '0; i_bv = '0; i_bc = '0;
    #1;
    n_vec++;
    if ({o_vl, o_cnt, o_data, o_done, o_busy, o_ovf} !== 39'd0) begin
      n_err++; $display("FAIL reset_mid: got %h expected 0", {o_vl, o_cnt, o_data, o_done, o_busy, o_ovf});
    end
    #1;
    rstn = 1'b1;
    model_reset();
    step(1'b0, 5'd0, 9'd0, 4'd0, 1'b1);
    for (int i = 0; i < 4 && !seen; i++) begin
      step(1'b0, 5'd0, 9'd0, 4'd0, 1'b0);
      n_vec++;
      if (o_vl !== 1'b0 || got !== exp) begin
        n_err++; $display("FAIL reset_mid_flush: got %h expected %h", got, exp);
      end
      if (o_done) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL reset_mid_done: got done=0 expected done=1"); end
  endtask

  task automatic test_ovf_busy();
    apply_reset();
    step(1'b0, 5'd0, 9'd0, 4'd0, 1'b1);
    step(1'b1, 5'd5, 9'd0, 4'd0, 1'b0);
    n_vec++;
    if (o_ovf !== 1'b1 || got !== exp) begin
      n_err++; $display("FAIL ovf_set: got ovf=%0b (%h) expected ovf=1 (%h)", o_ovf, got, exp);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 9'd0, 4'd0, 1'b0);
      n_vec++;
      if (o_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky cyc %0d: got ovf=%0b expected 1", i, o_ovf); end
    end
    apply_reset();
    #1;
    n_vec++;
    if (o_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got ovf=%0b expected 0", o_ovf); end
  endtask

  task automatic test_random();
    int guard;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_mode != 0)
        step(1'b0, 5'd0, 9'd0, 4'd0, 1'b0);
      else
        step(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 24)), 9'($urandom),
             4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL random cyc %0d: got %h expected %h", i, got, exp); end
    end
    guard = 0;
    while (m_mode != 0 && guard < 10) begin
      step(1'b0, 5'd0, 9'd0, 4'd0, 1'b0);
      guard++;
    end
    step(1'b0, 5'd0, 9'd0, 4'd0, 1'b1);
    guard = 0;
    while (m_mode != 0 && guard < 10) begin
      step(1'b0, 5'd0, 9'd0, 4'd0, 1'b0);
      guard++;
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL random_drain: got %h expected %h", got, exp); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    test_reset();
    test_stuffing();
    test_short_flush();
    test_escape();
    test_flush_ff();
    test_noop();
    test_reset_mid();
    test_ovf_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/jls_bit_packer.md
Name: jls_bit_packer

Overview:
- Downstream neighbour of the regular-mode encoding pipeline. Consumes its per-pixel code descriptors (zero count, value bits, value bit count).
- Serialises them MSB-first into a byte stream with JPEG-LS marker bit stuffing.
- Emits up to 4 bytes per cycle to the stream/AXI output stage.
- Upstream has no backpressure. The block absorbs one descriptor every cycle and flags overflow if it ever cannot.

Parameters:
- ACC_W, 64, accumulator width in bits (must be at least 40)

Ports:
- clk  in  1  clock, all logic on posedge
- rstn  in  1  asynchronous active-low reset
- i_vl  in  1  descriptor valid
- i_zc  in  5  unary length incl. terminating 1 (0 = no bits)
- i_bv  in  9  value bits; only the i_bc LSBs are used
- i_bc  in  4  value bit count, 0..9
- i_flush  in  1  single-cycle pulse: pad to byte boundary and drain
- o_vl  out  1  output word valid
- o_data  out  32  bytes; [31:24] is the first byte
- o_cnt  out  3  number of valid bytes, 1..4 when o_vl is high, 0 otherwise
- o_busy  out  1  flush drain in progress
- o_done  out  1  one-cycle pulse when flush drain completes
- o_ovf  out  1  sticky error flag

Behaviour:
- Reset (async, rstn=0):
  - Clears the accumulator, bit count, prev_ff, flush state and all outputs.
  - Reset values: o_vl=0, o_data=0, o_cnt=0, o_busy=0, o_done=0, o_ovf=0.
  - Reset mid-stream discards pending bits. No partial byte is emitted.
- Symbol bits:
  - i_vl=1 with i_zc>0 appends (i_zc-1) zeros, then a 1, then i_bv[i_bc-1:0] MSB first.
  - Maximum is 24+9=33 bits.
  - i_vl=1 with i_zc=0 appends nothing, regardless of i_bc.
  - i_bc>9 is masked to 9.
- Append and extract in the same cycle:
  - The symbol is appended combinationally to the accumulator contents.
  - Then up to 4 bytes are extracted in order by a 4-deep combinational chain.
- Byte extraction:
  - prev_ff=0: needs 8 bits; byte = next 8 bits.
  - prev_ff=1: needs 7 bits; byte = {1'b0, next 7 bits} (stuffed zero).
  - Only complete bytes are extracted. prev_ff is set iff the emitted byte is 0xFF.
  - prev_ff persists across cycles.
- Outputs are registered: a symbol presented in cycle N produces its complete bytes on o_* in cycle N+1.
  - o_vl=1 iff o_cnt>0.
  - Unused low bytes of o_data are 0.
- Overflow:
  - If the bits remaining after extraction exceed ACC_W, set o_ovf (sticky until reset).
  - The excess new bits are dropped and the stream is corrupt from that point.
  - Normal streams never hit this; only pathological 0xFF runs approach it.
- Flush FSM, states IDLE, DRAIN, TAIL:
  - IDLE: on i_flush, any same-cycle i_vl symbol is appended first, then go to DRAIN with o_busy=1.
  - DRAIN: each cycle, extract up to 4 complete bytes.
    - When fewer than one byte's bits remain, zero-pad the remainder to a full byte (7- or 8-bit per prev_ff) and emit it.
    - If the final emitted byte is 0xFF, go to TAIL. Otherwise pulse o_done together with the last bytes and return to IDLE.
    - An empty accumulator on entry with prev_ff=0 gives o_done in the next cycle with o_vl=0.
  - TAIL: emit 0x00 (stuffed zero byte) with o_cnt=1, pulse o_done, clear prev_ff, go to IDLE.
  - After a completed flush, the accumulator is empty and prev_ff=0.
  - i_vl or i_flush while o_busy=1 is ignored and sets o_ovf.
- Width rules:
  - Bit count register is ceil(log2(ACC_W+1)) bits.
  - All shifts are logical.
  - No arithmetic wraps: counts are bounded by ACC_W+33.

Test Plan:
- Stuffing across symbols: 15 cycles of i_vl=1, i_zc=1, i_bc=0. Required: byte 0xFF one cycle after the 8th symbol, then 0x7F (stuffed 0, then seven 1s) one cycle after the 15th symbol, o_cnt=1 each time.
- Short code plus flush: i_zc=3, i_bc=2, i_bv=2, then i_flush. Required: bits 00110 padded to one byte; a single 0x30 with o_cnt=1 and o_done in the same cycle; o_busy is 1 for exactly one cycle.
- Escape code: i_zc=24, i_bc=8, i_bv=0x55 from empty state. Required: next cycle o_cnt=4, o_data=0x0000_0155.
- Flush after 0xFF: 8 symbols of i_zc=1, i_bc=0, then i_flush. Required: 0xFF, then next cycle 0x00 with o_cnt=1 and o_done=1.
- No-op and mask: i_vl=1, i_zc=0, i_bc=5 repeated 10 cycles. Required: o_vl stays 0 and no bits are accumulated; a following flush gives o_done with o_vl=0.
- Reset and overflow: assert rstn=0 with 5 bits pending. Required: all outputs 0, and a subsequent flush emits nothing. Separately, i_vl during o_busy sets o_ovf=1, which stays 1 until rstn=0.
